// File: rtl/game_state_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_state_ctrl_if
// Groups the game-flow signals exchanged between the game state controller
// and the rest of the breakout system.
//
// Signals:
//   startOfFrame  : one-cycle pulse per video frame          (to controller)
//   startKey      : debounced start/launch key, level        (to controller)
//   ballMissed    : one-cycle pulse, ball left bottom edge   (to controller)
//   bricksCleared : level, no bricks remain                  (to controller)
//   preStart      : ball clamped to bat                      (from controller)
//   launch        : one-cycle pulse that starts ball motion  (from controller)
//   gameActive    : high in PRE_START, PLAY and LOST         (from controller)
//   livesLeft     : remaining lives, 2 bits                  (from controller)
//   gameOver      : high in OVER                             (from controller)
//   gameWon       : high in WON                              (from controller)
//
// Modports:
//   master : the environment side (drives the game events)
//   slave  : the controller side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface game_state_ctrl_if;
  logic       startOfFrame;
  logic       startKey;
  logic       ballMissed;
  logic       bricksCleared;
  logic       preStart;
  logic       launch;
  logic       gameActive;
  logic [1:0] livesLeft;
  logic       gameOver;
  logic       gameWon;

  modport master (
    output startOfFrame, startKey, ballMissed, bricksCleared,
    input  preStart, launch, gameActive, livesLeft, gameOver, gameWon
  );

  modport slave (
    input  startOfFrame, startKey, ballMissed, bricksCleared,
    output preStart, launch, gameActive, livesLeft, gameOver, gameWon
  );
endinterface

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
// Top-level game flow controller for the breakout game: waits for a start
// key, holds the ball on the bat until launch, tracks lives across misses,
// pauses between lives, and reports game over / game won.
//
// Ports:
//   clk    : system clock, single domain
//   reset  : synchronous, active-high reset
//   gameIf : game_state_ctrl_if.slave, game events in and status out
//
// Parameters:
//   LIVES       : lives granted at game start (1..3)
//   LOST_DELAY  : frames spent in LOST before the ball is re-served (1..63)
//   AUTO_LAUNCH : frames in PRE_START before an automatic launch (1..255)
//
// Optional feature macro: AUTO_LAUNCH_EN
//   Defined   -> PRE_START also launches on its own after AUTO_LAUNCH frames.
//   Undefined -> PRE_START waits for the key only; frame counter stays idle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module game_state_ctrl #(
  parameter int LIVES       = 3,
  parameter int LOST_DELAY  = 60,
  parameter int AUTO_LAUNCH = 180
) (
  input  logic              clk,
  input  logic              reset,
  game_state_ctrl_if.slave  gameIf
);

  typedef enum logic [2:0] {
    IDLE,
    PRE_START,
    PLAY,
    LOST,
    OVER,
    WON
  } state_e;

  localparam logic [1:0] LIVES_C       = 2'(LIVES);
  localparam logic [7:0] LOST_DELAY_C  = 8'(LOST_DELAY);
  localparam logic [7:0] AUTO_LAUNCH_C = 8'(AUTO_LAUNCH);

  state_e     state_q, state_d;
  logic [1:0] livesLeft_q, livesLeft_d;
  logic [7:0] frameCnt_q, frameCnt_d;
  logic       launch_q, launch_d;
  logic       keyPrev_q;

  logic       keyEdge;
  logic [7:0] frameLimit;
  logic       frameDone;

  // The key register resets to 1 so a key already held during reset
  // never looks like a fresh press.
  assign keyEdge = gameIf.startKey & ~keyPrev_q;

  // One comparator serves both counting states; only the current state's
  // limit matters, and the pulse that completes the count is the one
  // that triggers the exit.
  assign frameLimit = (state_q == PRE_START) ? AUTO_LAUNCH_C : LOST_DELAY_C;
  assign frameDone  = gameIf.startOfFrame && ((frameCnt_q + 8'd1) == frameLimit);

  // State, lives, frame counter, launch pulse and key history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      livesLeft_q <= 2'd0;
      frameCnt_q  <= 8'd0;
      launch_q    <= 1'b0;
      keyPrev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      livesLeft_q <= livesLeft_d;
      frameCnt_q  <= frameCnt_d;
      launch_q    <= launch_d;
      keyPrev_q   <= gameIf.startKey;
    end
  end

  // Next-state logic. The frame counter defaults to zero so that every
  // state transition clears it; only the counting states keep or advance
  // it, which also means a frame pulse on a transition is never counted
  // in the new state.
  always_comb begin
    state_d     = state_q;
    livesLeft_d = livesLeft_q;
    frameCnt_d  = 8'd0;
    launch_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (keyEdge) begin
          state_d     = PRE_START;
          livesLeft_d = LIVES_C;
        end
      end

      PRE_START: begin
`ifdef AUTO_LAUNCH_EN
        // A key press landing on the final frame still yields one launch.
        if (keyEdge || frameDone) begin
          state_d  = PLAY;
          launch_d = 1'b1;
        end else if (gameIf.startOfFrame) begin
          frameCnt_d = frameCnt_q + 8'd1;
        end else begin
          frameCnt_d = frameCnt_q;
        end
`else
        if (keyEdge) begin
          state_d  = PLAY;
          launch_d = 1'b1;
        end
`endif
      end

      PLAY: begin
        // Clearing the last brick beats a simultaneous miss.
        if (gameIf.bricksCleared) begin
          state_d = WON;
        end else if (gameIf.ballMissed) begin
          if (livesLeft_q > 2'd1) begin
            livesLeft_d = livesLeft_q - 2'd1;
            state_d     = LOST;
          end else begin
            livesLeft_d = 2'd0;
            state_d     = OVER;
          end
        end
      end

      LOST: begin
        if (frameDone) begin
          state_d = PRE_START;
        end else if (gameIf.startOfFrame) begin
          frameCnt_d = frameCnt_q + 8'd1;
        end else begin
          frameCnt_d = frameCnt_q;
        end
      end

      OVER, WON: begin
        if (keyEdge) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs come straight from registers or from the registered state.
  assign gameIf.preStart   = (state_q == PRE_START);
  assign gameIf.launch     = launch_q;
  assign gameIf.gameActive = (state_q == PRE_START) || (state_q == PLAY) ||
                             (state_q == LOST);
  assign gameIf.livesLeft  = livesLeft_q;
  assign gameIf.gameOver   = (state_q == OVER);
  assign gameIf.gameWon    = (state_q == WON);

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter LIVES, default 3, lives granted at game start; legal range 1..3.
REQ-002 Parameter LOST_DELAY, default 60, frames spent in LOST before re-serve; legal range 1..63.
REQ-003 Parameter AUTO_LAUNCH, default 180, frames in PRE_START before automatic launch (used only when AUTO_LAUNCH_EN is defined); legal range 1..255.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startOfFrame  input  1  one-cycle pulse per video frame.
REQ-007 startKey  input  1  debounced start/launch key, level.
REQ-008 ballMissed  input  1  one-cycle pulse when the ball passes the bottom edge.
REQ-009 bricksCleared  input  1  level, high when no bricks remain.
REQ-010 preStart  output  1  high in PRE_START only; drives the ball-position mux selector (ball clamped to bat).
REQ-011 launch  output  1  one-cycle pulse on every PRE_START->PLAY transition; starts ball motion.
REQ-012 gameActive  output  1  high in PRE_START, PLAY and LOST.
REQ-013 livesLeft  output  2  remaining lives.
REQ-014 gameOver  output  1  high in OVER.
REQ-015 gameWon  output  1  high in WON.

Function
REQ-016 The FSM SHALL have exactly six states: IDLE, PRE_START, PLAY, LOST, OVER, WON.
REQ-017 keyEdge SHALL be startKey AND NOT startKey-registered; the registered copy resets to 1, so a key held through reset never triggers.
REQ-018 IDLE: on keyEdge SHALL go to PRE_START and load livesLeft=LIVES in the same cycle.
REQ-019 PRE_START: on keyEdge SHALL go to PLAY; launch SHALL be high in the cycle the state register becomes PLAY (one cycle).
REQ-020 PLAY: bricksCleared SHALL move to WON; when bricksCleared and ballMissed coincide, WON wins and lives are unchanged.
REQ-021 PLAY: on ballMissed with livesLeft>1 SHALL decrement livesLeft and go to LOST; with livesLeft==1 SHALL set livesLeft=0 and go to OVER.
REQ-022 LOST: SHALL count startOfFrame pulses in an 8-bit frame counter cleared on state entry; on the LOST_DELAY-th pulse SHALL go to PRE_START.
REQ-023 OVER and WON: SHALL hold until keyEdge, then go to IDLE; livesLeft holds its value until the next IDLE->PRE_START load.
REQ-024 ballMissed and keyEdge SHALL be ignored in every state not listed as consuming them; startOfFrame coinciding with a state transition SHALL NOT be counted in the new state.
REQ-025 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-026 livesLeft SHALL never wrap below 0 nor exceed LIVES.

Reset
REQ-027 A synchronous reset SHALL force state=IDLE, livesLeft=0, frame counter=0, key register=1, and launch, preStart, gameActive, gameOver and gameWon all 0, taking effect on the next clk edge, including mid-LOST or mid-PLAY.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 Macro AUTO_LAUNCH_EN: when defined, PRE_START SHALL count startOfFrame pulses (counter cleared on entry) and go to PLAY with launch on the AUTO_LAUNCH-th pulse; keyEdge still launches immediately, and a keyEdge coinciding with the final count produces a single launch pulse.
REQ-030 When AUTO_LAUNCH_EN is undefined, PRE_START SHALL exit only on keyEdge and the frame counter SHALL be idle in PRE_START.

Verification
REQ-031 Reset, then keyEdge -> PRE_START, livesLeft=3, preStart=1; second keyEdge -> launch high for exactly 1 cycle, state PLAY, preStart=0.
REQ-032 PLAY, 3 ballMissed pulses each followed by 60 startOfFrame pulses and a keyEdge -> livesLeft 2, 1, then 0 with gameOver=1 and no LOST entry on the third miss.
REQ-033 PLAY, ballMissed and bricksCleared in the same cycle with livesLeft=2 -> gameWon=1, livesLeft=2.
REQ-034 LOST after 30 of 60 frames, reset asserted -> next cycle IDLE, all outputs 0; startKey held high through reset release -> no transition.
REQ-035 AUTO_LAUNCH_EN defined, AUTO_LAUNCH=4, PRE_START with no key -> launch on the cycle after the 4th startOfFrame pulse; keyEdge on that same pulse -> one launch pulse only.
